// File: rtl/osd_vram_wr_sched_if.sv
// CPU write-request and VRAM write-port bundle for the OSD VRAM write scheduler.
interface osd_vram_wr_sched_if #(
  parameter int unsigned C_AW = 10,
  parameter int unsigned C_DW = 8
);
  logic            CPU_WE_i;
  logic [C_AW-1:0] CPU_WAs_i;
  logic [C_DW-1:0] CPU_WDs_i;
  logic            OVF_CLR_i;
  logic            CPU_FULL_o;
  logic            CPU_OVF_o;
  logic [C_AW-1:0] VRAM_WAs_o;
  logic [C_DW-1:0] VRAM_WDs_o;
  logic            VRAM_WE_o;

  modport master (
    output CPU_WE_i, CPU_WAs_i, CPU_WDs_i, OVF_CLR_i,
    input  CPU_FULL_o, CPU_OVF_o, VRAM_WAs_o, VRAM_WDs_o, VRAM_WE_o
  );

  modport slave (
    input  CPU_WE_i, CPU_WAs_i, CPU_WDs_i, OVF_CLR_i,
    output CPU_FULL_o, CPU_OVF_o, VRAM_WAs_o, VRAM_WDs_o, VRAM_WE_o
  );
endinterface

// File: rtl/osd_vram_wr_sched.sv
// Merges a CPU write FIFO (priority) and a range fill engine onto the single
// OSD character VRAM write port, one write per pixel clock enable.
module osd_vram_wr_sched #(
  parameter int unsigned C_AW        = 10,
  parameter int unsigned C_DW        = 8,
  parameter int unsigned C_FIFO_LOG2 = 2
) (
  input  logic                CK_i,
  input  logic                XAR_i,
  input  logic                CK_EE_i,
  input  logic                XVD_i,
  input  logic                WR_EN_i,
  osd_vram_wr_sched_if.slave  bus_if,
  input  logic                FILL_REQ_i,
  input  logic                FILL_VSYNC_i,
  input  logic [C_AW-1:0]     FILL_BASEs_i,
  input  logic [C_AW:0]       FILL_LENs_i,
  input  logic [C_DW-1:0]     FILL_DATs_i,
  input  logic                FILL_ABORT_i,
  output logic                FILL_BUSY_o,
  output logic                FILL_DONE_o
);

  localparam int unsigned C_DEPTH = 1 << C_FIFO_LOG2;
  localparam int unsigned C_CW    = C_FIFO_LOG2 + 1;
  localparam int unsigned C_LW    = C_AW + 1;
  localparam int unsigned C_EW    = C_AW + C_DW;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_FILL} state_e;

  state_e                 state_q, state_d;
  logic [C_AW-1:0]        fadr_q, fadr_d;
  logic [C_LW-1:0]        flen_q, flen_d;
  logic [C_DW-1:0]        fdat_q, fdat_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [C_AW-1:0]        wa_q, wa_d;
  logic [C_DW-1:0]        wd_q, wd_d;
  logic                   we_q, we_d;
  logic [C_EW-1:0]        mem_q [C_DEPTH];
  logic [C_FIFO_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [C_CW-1:0]        cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   full, push, pop, fill_ok, fill_wr;

  assign full = (cnt_q == C_CW'(C_DEPTH));

  // Next-state: FIFO bookkeeping, write-port arbitration and fill FSM.
  always_comb begin
    state_d = state_q;
    fadr_d  = fadr_q;
    flen_d  = flen_q;
    fdat_d  = fdat_q;
    done_d  = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = we_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    fill_wr = 1'b0;
    push    = bus_if.CPU_WE_i && !full;
    // The vsync edge itself already carries the first fill write.
    fill_ok = (state_q == S_FILL) || ((state_q == S_ARM) && CK_EE_i && !XVD_i);

    if (CK_EE_i) begin
      we_d = 1'b0;
      if (WR_EN_i) begin
        if (cnt_q != '0) begin
          pop  = 1'b1;
          wa_d = mem_q[rd_q][C_EW-1:C_DW];
          wd_d = mem_q[rd_q][C_DW-1:0];
          we_d = 1'b1;
        end else if (fill_ok && !FILL_ABORT_i) begin
          fill_wr = 1'b1;
          wa_d    = fadr_q;
          wd_d    = fdat_q;
          we_d    = 1'b1;
        end
      end
    end

    if (push) wr_d = wr_q + C_FIFO_LOG2'(1);
    if (pop)  rd_d = rd_q + C_FIFO_LOG2'(1);
    cnt_d = cnt_q + C_CW'(push) - C_CW'(pop);

    if (bus_if.CPU_WE_i && full) ovf_d = 1'b1;
    else if (bus_if.OVF_CLR_i)   ovf_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (FILL_REQ_i) begin
          if (FILL_LENs_i == '0) begin
            done_d = 1'b1;
          end else begin
            fadr_d  = FILL_BASEs_i;
            flen_d  = FILL_LENs_i;
            fdat_d  = FILL_DATs_i;
            state_d = FILL_VSYNC_i ? S_ARM : S_FILL;
          end
        end
      end
      S_ARM: begin
        if (FILL_ABORT_i)            state_d = S_IDLE;
        else if (CK_EE_i && !XVD_i)  state_d = S_FILL;
      end
      S_FILL: begin
        if (FILL_ABORT_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fill_wr) begin
      fadr_d = fadr_q + C_AW'(1);
      flen_d = flen_q - C_LW'(1);
      if (flen_q == C_LW'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      state_q <= S_IDLE;
      fadr_q  <= '0;
      flen_q  <= '0;
      fdat_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fadr_q  <= fadr_d;
      flen_q  <= flen_d;
      fdat_q  <= fdat_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      for (int i = 0; i < int'(C_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= {bus_if.CPU_WAs_i, bus_if.CPU_WDs_i};
    end
  end

  assign bus_if.CPU_FULL_o = full;
  assign bus_if.CPU_OVF_o  = ovf_q;
  assign bus_if.VRAM_WAs_o = wa_q;
  assign bus_if.VRAM_WDs_o = wd_q;
  assign bus_if.VRAM_WE_o  = we_q;
  assign FILL_BUSY_o       = busy_q;
  assign FILL_DONE_o       = done_q;

endmodule
